// File: rtl/pattern_pkg.sv
// Shared constants and FSM state type for the HOMEWORK pattern sender and its matching detector.
package pattern_pkg;

    localparam int                     WORD_LEN  = 8;
    localparam logic [8*WORD_LEN-1:0]  WORD      = "HOMEWORK";
    localparam logic [7:0]             IDLE_CHAR = 8'h20;
    localparam logic [2:0]             LAST_IDX  = 3'(WORD_LEN - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SEND   = 2'd1,
        ST_GAP    = 2'd2,
        ST_FINISH = 2'd3
    } state_t;

endpackage

// File: rtl/pattern_rom.sv
// Combinational lookup of one character of WORD from a 3-bit index (index 0 = first character).
module pattern_rom
    import pattern_pkg::*;
(
    input  logic [2:0] index_i,
    output logic [7:0] char_o
);

    always_comb begin
        char_o = IDLE_CHAR;
        for (int i = 0; i < WORD_LEN; i++) begin
            if (index_i == 3'(i)) begin
                char_o = WORD[8*(WORD_LEN-1-i) +: 8];
            end
        end
    end

endmodule

// File: rtl/word_pattern_sender.sv
// Sends WORD one registered character per cycle, with receiver stall and optional stall timeout.
// Define SENDER_LOOP_EN to repeat the word with GAP_CYCLES idle cycles between repetitions.
//
// state  | meaning
// IDLE   | waiting for start, idle character on the output
// SEND   | presenting WORD[index] (or idle char while hold stalls)
// GAP    | idle cycles between repetitions (loop build only)
// FINISH | one-cycle done pulse after the last character
module word_pattern_sender
    import pattern_pkg::*;
#(
    parameter int GAP_CYCLES  = 2,
    parameter int STALL_LIMIT = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       hold,
    output logic [7:0] letter,
    output logic       letter_valid,
    output logic       busy,
    output logic       done,
    output logic       aborted
);

    localparam bit         STALL_EN  = (STALL_LIMIT != 0);
    localparam logic [7:0] STALL_LIM = 8'(STALL_LIMIT);

    state_t     state_q, state_d;
    logic [2:0] index_q, index_d;
    logic [7:0] stall_q, stall_d;
    logic [7:0] letter_q, letter_d;
    logic       valid_q, valid_d;
    logic       done_q, done_d;
    logic       aborted_q, aborted_d;

    logic [7:0] stall_inc;
    logic [2:0] rom_idx;
    logic [7:0] rom_char;

    // index_q is the position currently on the output, so the lookup is for the one after it.
    assign rom_idx   = (state_q == ST_SEND) ? index_q + 3'd1 : 3'd0;
    assign stall_inc = stall_q + 8'd1;

    pattern_rom u_rom (
        .index_i (rom_idx),
        .char_o  (rom_char)
    );

`ifdef SENDER_LOOP_EN
    localparam logic [3:0] GAP_LOAD = 4'(GAP_CYCLES - 1);

    logic [3:0] gap_q, gap_d;
    logic       stop_q, stop_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            gap_q  <= '0;
            stop_q <= 1'b0;
        end else begin
            gap_q  <= gap_d;
            stop_q <= stop_d;
        end
    end
`else
    logic unused_gap_cfg;
    assign unused_gap_cfg = (GAP_CYCLES != 0);
`endif

    always_comb begin
        state_d   = state_q;
        index_d   = index_q;
        stall_d   = stall_q;
        letter_d  = IDLE_CHAR;
        valid_d   = 1'b0;
        done_d    = 1'b0;
        aborted_d = 1'b0;
`ifdef SENDER_LOOP_EN
        gap_d     = gap_q;
        stop_d    = stop_q;
`endif
        case (state_q)
            ST_IDLE: begin
                stall_d = '0;
`ifdef SENDER_LOOP_EN
                stop_d  = 1'b0;
`endif
                if (start) begin
                    state_d  = ST_SEND;
                    index_d  = '0;
                    letter_d = rom_char;
                    valid_d  = 1'b1;
                end
            end
            ST_SEND: begin
                if (hold) begin
                    if (STALL_EN && (stall_inc == STALL_LIM)) begin
                        state_d   = ST_IDLE;
                        stall_d   = '0;
                        aborted_d = 1'b1;
                    end else if (stall_q != 8'hFF) begin
                        stall_d = stall_inc;
                    end
                end else begin
                    stall_d = '0;
                    if (index_q == LAST_IDX) begin
                        state_d = ST_FINISH;
                        done_d  = 1'b1;
                    end else begin
                        index_d  = index_q + 3'd1;
                        letter_d = rom_char;
                        valid_d  = 1'b1;
                    end
                end
            end
            ST_FINISH: begin
`ifdef SENDER_LOOP_EN
                if (stop_q) begin
                    state_d = ST_IDLE;
                    stop_d  = 1'b0;
                end else begin
                    state_d = ST_GAP;
                    gap_d   = GAP_LOAD;
                end
`else
                state_d = ST_IDLE;
`endif
            end
            ST_GAP: begin
`ifdef SENDER_LOOP_EN
                if (start) begin
                    stop_d = 1'b1;
                end
                if (gap_q == 4'd0) begin
                    state_d  = ST_SEND;
                    index_d  = '0;
                    stall_d  = '0;
                    letter_d = rom_char;
                    valid_d  = 1'b1;
                end else begin
                    gap_d = gap_q - 4'd1;
                end
`else
                state_d = ST_IDLE;
`endif
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            index_q   <= '0;
            stall_q   <= '0;
            letter_q  <= IDLE_CHAR;
            valid_q   <= 1'b0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            index_q   <= index_d;
            stall_q   <= stall_d;
            letter_q  <= letter_d;
            valid_q   <= valid_d;
            done_q    <= done_d;
            aborted_q <= aborted_d;
        end
    end

    assign letter       = letter_q;
    assign letter_valid = valid_q;
    assign busy         = (state_q == ST_SEND) || (state_q == ST_GAP);
    assign done         = done_q;
    assign aborted      = aborted_q;

endmodule

// File: tb/tb_word_pattern_sender.sv
// Bench for word_pattern_sender: cycle-by-cycle compare against a word-level model plus directed literal checks.
module tb_word_pattern_sender;

    localparam int GAP = 2;
    localparam int LIM = 3;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b1;
    logic       start = 1'b0;
    logic       hold  = 1'b0;
    logic [7:0] letter;
    logic       letter_valid, busy, done, aborted;

    int tests_run    = 0;
    int tests_failed = 0;

    word_pattern_sender #(.GAP_CYCLES(GAP), .STALL_LIMIT(LIM)) dut (
        .clk          (clk),
        .rst          (rst_n),
        .start        (start),
        .hold         (hold),
        .letter       (letter),
        .letter_valid (letter_valid),
        .busy         (busy),
        .done         (done),
        .aborted      (aborted)
    );

    always #5 clk = ~clk;

    // Model: phase 0 idle, 1 sending, 2 finish, 3 gap; m_pos = characters of the word shown so far.
    string WORD_S = "HOMEWORK";
    int    m_phase, m_pos, m_stall, m_gapleft;
    bit    m_show, m_stop, m_ab;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase = 0; m_pos = 0; m_stall = 0; m_gapleft = 0;
            m_show = 0; m_stop = 0; m_ab = 0;
        end else begin
            m_ab = 0;
            case (m_phase)
                0: begin
                    m_stop = 0;
                    if (start) begin m_phase = 1; m_pos = 1; m_show = 1; m_stall = 0; end
                end
                1: begin
                    if (hold) begin
                        m_stall++;
                        m_show = 0;
                        if (LIM != 0 && m_stall >= LIM) begin m_phase = 0; m_ab = 1; m_stall = 0; end
                    end else begin
                        m_stall = 0;
                        if (m_pos == 8) begin m_phase = 2; m_show = 0; end
                        else begin m_pos++; m_show = 1; end
                    end
                end
                2: begin
`ifdef SENDER_LOOP_EN
                    if (m_stop) begin m_phase = 0; m_stop = 0; end
                    else begin m_phase = 3; m_gapleft = GAP; end
`else
                    m_phase = 0;
`endif
                end
                default: begin
                    if (start) m_stop = 1;
                    m_gapleft--;
                    if (m_gapleft == 0) begin m_phase = 1; m_pos = 1; m_show = 1; m_stall = 0; end
                end
            endcase
        end
    end

    always @(negedge clk) begin
        logic [7:0] el;
        logic       eb;
        el = m_show ? 8'(WORD_S[m_pos-1]) : 8'h20;
        eb = (m_phase == 1) || (m_phase == 3);
        tests_run++;
        if (letter !== el || letter_valid !== m_show || busy !== eb ||
            done !== (m_phase == 2) || aborted !== m_ab) begin
            tests_failed++;
            $display("FAIL cycle_cmp t=%0t got letter=%h valid=%b busy=%b done=%b aborted=%b exp letter=%h valid=%b busy=%b done=%b aborted=%b",
                     $time, letter, letter_valid, busy, done, aborted, el, m_show, eb, m_phase == 2, m_ab);
        end
    end

    logic [7:0] lg_letter [64];
    bit         lg_valid  [64];
    bit         lg_busy   [64];
    bit         lg_done   [64];
    bit         lg_ab     [64];

    // Bit i of sp/hp is sampled at edge i; outputs of the following cycle are logged at index i+1.
    task automatic run_seq(input int n, input logic [63:0] sp, input logic [63:0] hp);
        for (int i = 0; i < 64; i++) begin
            lg_letter[i] = 8'h00; lg_valid[i] = 0; lg_busy[i] = 0; lg_done[i] = 0; lg_ab[i] = 0;
        end
        for (int i = 0; i < n; i++) begin
            start = sp[i];
            hold  = hp[i];
            @(negedge clk);
            #2;
            lg_letter[i+1] = letter;
            lg_valid[i+1]  = letter_valid;
            lg_busy[i+1]   = busy;
            lg_done[i+1]   = done;
            lg_ab[i+1]     = aborted;
        end
        start = 0;
        hold  = 0;
    endtask

    function automatic string got_word(input int n);
        string s = "";
        for (int i = 1; i <= n; i++) if (lg_valid[i]) s = $sformatf("%s%c", s, lg_letter[i]);
        return s;
    endfunction

    function automatic int count_done(input int n);
        int c = 0;
        for (int i = 1; i <= n; i++) if (lg_done[i]) c++;
        return c;
    endfunction

    function automatic int first_done(input int n);
        for (int i = 1; i <= n; i++) if (lg_done[i]) return i;
        return -1;
    endfunction

    function automatic int count_busy(input int n);
        int c = 0;
        for (int i = 1; i <= n; i++) if (lg_busy[i]) c++;
        return c;
    endfunction

    function automatic int count_ab(input int n);
        int c = 0;
        for (int i = 1; i <= n; i++) if (lg_ab[i]) c++;
        return c;
    endfunction

    function automatic int first_ab(input int n);
        for (int i = 1; i <= n; i++) if (lg_ab[i]) return i;
        return -1;
    endfunction

    task automatic chk(input string nm, input int got, input int exp);
        tests_run++;
        if (got != exp) begin
            tests_failed++;
            $display("FAIL %s got %0d exp %0d", nm, got, exp);
        end
    endtask

    task automatic chk_s(input string nm, input string got, input string exp);
        tests_run++;
        if (got != exp) begin
            tests_failed++;
            $display("FAIL %s got \"%s\" exp \"%s\"", nm, got, exp);
        end
    endtask

    initial begin
        #1 rst_n = 0;
        @(negedge clk); #2;
        chk("rst_letter", int'(letter), 32);
        chk("rst_valid", int'(letter_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done_abort", int'(done | aborted), 0);
        rst_n = 1;
        @(negedge clk); #2;

`ifndef SENDER_LOOP_EN
        // Plain word
        run_seq(12, 64'h1, 64'h0);
        chk_s("t1_word", got_word(12), "HOMEWORK");
        chk("t1_first_H", int'(lg_letter[1]), 72);
        chk("t1_done_cycle", first_done(12), 9);
        chk("t1_done_count", count_done(12), 1);
        chk("t1_busy_count", count_busy(12), 8);
        chk("t1_busy_c9", int'(lg_busy[9]), 0);
        chk("t1_letter_c9", int'(lg_letter[9]), 32);

        // Hold for two edges after M
        run_seq(14, 64'h1, 64'h18);
        chk("t2_M_c3", int'(lg_letter[3]), 77);
        chk("t2_idle_c4", int'(lg_letter[4]), 32);
        chk("t2_valid_c4", int'(lg_valid[4]), 0);
        chk("t2_idle_c5", int'(lg_letter[5]), 32);
        chk("t2_E_c6", int'(lg_letter[6]), 69);
        chk_s("t2_word", got_word(14), "HOMEWORK");
        chk("t2_done_cycle", first_done(14), 11);
        chk("t2_no_abort", count_ab(14), 0);

        // Stall timeout after O
        run_seq(8, 64'h1, 64'h1C);
        chk("t3_abort_cycle", first_ab(8), 5);
        chk("t3_abort_count", count_ab(8), 1);
        chk("t3_no_done", count_done(8), 0);
        chk("t3_busy_c4", int'(lg_busy[4]), 1);
        chk("t3_busy_c5", int'(lg_busy[5]), 0);
        chk_s("t3_word", got_word(8), "HO");
        run_seq(12, 64'h1, 64'h0);
        chk_s("t3_restart_word", got_word(12), "HOMEWORK");
        chk("t3_restart_done", first_done(12), 9);

        // start while busy and during FINISH is ignored
        run_seq(14, 64'h211, 64'h0);
        chk_s("t4_word", got_word(14), "HOMEWORK");
        chk("t4_done_count", count_done(14), 1);
        chk("t4_busy_count", count_busy(14), 8);
        chk("t4_busy_c10", int'(lg_busy[10]), 0);

        // hold in IDLE and FINISH has no effect
        run_seq(12, 64'h1, 64'h201);
        chk("t5_first_H", int'(lg_letter[1]), 72);
        chk("t5_done_cycle", first_done(12), 9);
        chk("t5_busy_c10", int'(lg_busy[10]), 0);

        // Reset mid-word
        run_seq(5, 64'h1, 64'h0);
        chk("t6_W_c5", int'(lg_letter[5]), 87);
        rst_n = 0;
        #1;
        chk("t6_rst_letter", int'(letter), 32);
        chk("t6_rst_valid", int'(letter_valid), 0);
        chk("t6_rst_busy", int'(busy), 0);
        @(negedge clk); #2;
        rst_n = 1;
        run_seq(6, 64'h0, 64'h0);
        chk("t6_no_done", count_done(6), 0);
        chk("t6_stays_idle", count_busy(6), 0);
        run_seq(12, 64'h1, 64'h0);
        chk("t6_new_H", int'(lg_letter[1]), 72);
        chk_s("t6_word", got_word(12), "HOMEWORK");
`else
        // Loop mode: start again during the first gap stops after one more word
        run_seq(26, 64'h401, 64'h0);
        chk_s("loop_word", got_word(26), "HOMEWORKHOMEWORK");
        chk("loop_done_first", first_done(26), 9);
        chk("loop_done_second", int'(lg_done[20]), 1);
        chk("loop_done_count", count_done(26), 2);
        chk("loop_gap_valid_c10", int'(lg_valid[10]), 0);
        chk("loop_gap_busy_c10", int'(lg_busy[10]), 1);
        chk("loop_gap_busy_c11", int'(lg_busy[11]), 1);
        chk("loop_H_c12", int'(lg_letter[12]), 72);
        chk("loop_idle_c21", int'(lg_busy[21]), 0);
        chk("loop_idle_c25", int'(lg_busy[25]), 0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
